// File: rtl/binary_to_onehot.sv
// rtl/binary_to_onehot.sv - registered binary-to-one-hot decoder with valid qualifier
//
// Purpose:
//   Captures a BIN_W-bit binary index when valid_i is high and presents the
//   decoded 2**BIN_W-bit one-hot vector one cycle later. valid_o is high only
//   in the cycle after a capture. When valid_i is low, one_hot_o keeps its last
//   value. Every output comes straight from a flop.
//
// Optional feature:
//   Macro BIN2OH_CHECK_EN adds the err_o port and a registered integrity
//   checker. err_o is a sticky flag that rises when a freshly presented
//   one_hot_o is not exactly one-hot, or when it does not re-encode to the
//   captured index.
//
// Parameters:
//   BIN_W     binary index width, 1..8
//   OH_W      one-hot width, derived as 2**BIN_W (do not override)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   valid_i    capture bin_i this cycle
//   bin_i      binary index, 0..OH_W-1
//   valid_o    one_hot_o holds a freshly decoded value
//   one_hot_o  decoded vector, bit n set iff the captured index is n
//   err_o      sticky integrity error (only with BIN2OH_CHECK_EN)

module binary_to_onehot #(
  parameter int BIN_W = 4,
  parameter int OH_W  = 2 ** BIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             valid_o,
  output logic [OH_W-1:0]  one_hot_o
`ifdef BIN2OH_CHECK_EN
  ,
  output logic             err_o
`endif
);

  // Combinational decode of the incoming index. Every index is in range
  // because OH_W covers all 2**BIN_W codes.
  logic [OH_W-1:0] decoded;

  always_comb begin
    decoded        = '0;
    decoded[bin_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      one_hot_o <= '0;
      valid_o   <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        one_hot_o <= decoded;
      end
    end
  end

`ifdef BIN2OH_CHECK_EN
  // Keep an independent copy of the captured index. The checker then compares
  // the decoder flops against a separate path, rather than against themselves.
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W:0]   pop_cnt;
  logic [BIN_W-1:0] re_enc;
  logic             mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
    end else if (valid_i) begin
      bin_q <= bin_i;
    end
  end

  // Count the set bits and re-encode the highest set bit. Any vector that is
  // not a single bit at position bin_q is flagged.
  always_comb begin
    pop_cnt = '0;
    re_enc  = '0;
    for (int n = 0; n < OH_W; n++) begin
      if (one_hot_o[n]) begin
        pop_cnt = pop_cnt + (BIN_W+1)'(1);
        re_enc  = BIN_W'(n);
      end
    end
    mismatch = (pop_cnt != (BIN_W+1)'(1)) || (re_enc != bin_q);
  end

  // Only a freshly presented value is judged. The flag stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_o <= 1'b0;
    end else if (valid_o && mismatch) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_binary_to_onehot.sv
// tb/tb_binary_to_onehot.sv - scoreboard bench for binary_to_onehot with random stimulus

module tb_binary_to_onehot;

  localparam int BIN_W = 4;
  localparam int OH_W  = 2 ** BIN_W;

  logic             clk;
  logic             reset;
  logic             valid_i;
  logic [BIN_W-1:0] bin_i;
  logic             valid_o;
  logic [OH_W-1:0]  one_hot_o;
`ifdef BIN2OH_CHECK_EN
  logic             err_o;
`endif

  binary_to_onehot #(.BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .bin_i     (bin_i),
    .valid_o   (valid_o),
    .one_hot_o (one_hot_o)
`ifdef BIN2OH_CHECK_EN
    ,
    .err_o     (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            valid;
    logic [OH_W-1:0] oh;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: the last value that was decoded (zero after reset).
  logic [OH_W-1:0] model_oh = '0;

  function automatic void check(string name, logic [OH_W-1:0] act, logic [OH_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Apply one cycle of stimulus away from the clock edge. Then record what the
  // next rising edge must produce.
  task automatic drive(input logic r, input logic v, input int b);
    exp_t e;
    @(negedge clk);
    reset   = r;
    valid_i = v;
    bin_i   = BIN_W'(b);
    if (r) begin
      model_oh = '0;
      e.valid  = 1'b0;
    end else if (v) begin
      model_oh = OH_W'(2 ** b);
      e.valid  = 1'b1;
    end else begin
      e.valid  = 1'b0;
    end
    e.oh = model_oh;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs to the scoreboard after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid_o", OH_W'(valid_o), OH_W'(e.valid));
      check("one_hot_o", one_hot_o, e.oh);
`ifdef BIN2OH_CHECK_EN
      check("err_o", OH_W'(err_o), '0);
`endif
    end
  end

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    bin_i   = '0;

    // Reset held for two cycles while valid_i is high.
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b1, 5);

    // Exhaustive sweep, back to back.
    for (int i = 0; i < OH_W; i++) drive(1'b0, 1'b1, i);

    // Hold: the output stays at the last decode while valid_i is low.
    drive(1'b0, 1'b1, 3);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 12);

    // Boundaries.
    drive(1'b0, 1'b1, 0);
    drive(1'b0, 1'b1, OH_W - 1);

    // Mid-stream reset has priority over valid_i.
    drive(1'b0, 1'b1, 7);
    drive(1'b1, 1'b1, 9);
    drive(1'b0, 1'b1, 9);

    // Random traffic with occasional resets and idle cycles.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, OH_W - 1)));
    end
    drive(1'b0, 1'b0, 0);

    // Wait for the scoreboard to drain, with a bound.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_to_onehot.md
# binary_to_onehot

Registered binary-to-one-hot decoder. Converts a BIN_W-bit binary index into a 2^BIN_W-bit one-hot vector with exactly one bit set at position bin_i. It sits between index-producing control logic (arbiters, counters, address fields) and select/enable fan-out that needs decoded lines. It provides one-cycle registered latency and a valid qualifier.

## Interface
Parameters:
- BIN_W, default 4: binary input width; legal range 1..8.
- OH_W, default 2**BIN_W: one-hot output width; derived, must not be overridden.

Ports:
- clk  input  1: single clock; all state updates on rising edge.
- reset  input  1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- valid_i  input  1: bin_i is meaningful this cycle; capture and decode.
- bin_i  input  BIN_W: binary index, unsigned, 0..OH_W-1.
- valid_o  output  1: one_hot_o holds a freshly decoded value this cycle.
- one_hot_o  output  OH_W: decoded vector; bit n set iff captured index == n.
- err_o  output  1: one-hot integrity error; present only with BIN2OH_CHECK_EN.

## Operation
- On a rising clk with reset=1:
  - one_hot_o <= 0.
  - valid_o <= 0.
  - err_o <= 0 when the check feature is present.
- On a rising clk with reset=0 and valid_i=1:
  - one_hot_o <= 1 << bin_i, so exactly one bit is set.
  - valid_o <= 1.
- On a rising clk with reset=0 and valid_i=0:
  - one_hot_o holds its previous value.
  - valid_o <= 0.
- Every bin_i value in 0..2^BIN_W-1 maps to a distinct output bit, and there is no out-of-range index.
  - bin_i=0 gives bit 0 (LSB).
  - bin_i=2^BIN_W-1 gives the MSB.
- The decode is a pure function of the captured bin_i, with no dependence on history.
- Back-to-back valid_i cycles each produce a new output, giving full throughput of one decode per cycle.
- reset takes priority over valid_i in the same cycle.
- Reset asserted mid-stream clears the output on that edge. The first decode after deassertion behaves exactly as from power-up.
- The all-zero one_hot_o seen after reset is a legal "nothing decoded" state. valid_o=0 flags it.

## Timing
- Latency: 1 cycle. A value presented with valid_i at edge N appears on one_hot_o/valid_o after edge N, stable through edge N+1.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.
- There is no backpressure, and the block accepts an input every cycle.
- valid_o is high for exactly the cycles following a valid_i capture.

## Configuration
- Macro BIN2OH_CHECK_EN.
- Defined:
  - Adds output err_o and a registered checker on one_hot_o.
  - err_o is asserted the cycle after valid_o=1 if one_hot_o is not exactly one-hot (popcount != 1).
  - err_o is also asserted if the set bit differs from a re-encoded copy of the captured bin_i.
  - err_o is sticky until reset.
  - In a correct design err_o never rises. It exists to catch synthesis/ECO faults.
- Not defined:
  - No err_o port and no checker logic.
  - All other behaviour is identical.

## Test plan
- Reset: hold reset=1 for 2 cycles with valid_i=1, bin_i=4'h5 -> one_hot_o=16'h0000, valid_o=0 (err_o=0 if enabled).
- Exhaustive sweep: valid_i=1 and bin_i=0..15, one per cycle -> next cycle one_hot_o=16'h0001, 16'h0002, ... 16'h8000, valid_o=1 each cycle.
- Hold: decode bin_i=4'h3, then valid_i=0 for 3 cycles while bin_i=4'hC -> one_hot_o stays 16'h0008, valid_o=0.
- Boundaries: bin_i=4'h0 -> 16'h0001; bin_i=4'hF -> 16'h8000.
- Mid-stream reset: decode 4'h7 (16'h0080), then assert reset together with valid_i=1, bin_i=4'h9 -> 16'h0000, valid_o=0. Release and decode 4'h9 -> 16'h0200.
- Parameter BIN_W=3 with BIN2OH_CHECK_EN: sweep 0..7 -> 8'h01..8'h80, err_o=0 throughout.
